// File: rtl/sync_async_patmon.sv
`default_nettype none
// ============================================================================
// sync_async_patmon : pulse-set monitor (pulse count, first delay, widths, sets)
// Optional build macro PATMON_GLITCH_FILTER_EN. Revision 1.0
// ============================================================================
module sync_async_patmon (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       suspend,
  input  logic       write,
  input  logic [3:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       synced,
  input  logic       syncrst,
  input  logic       sig_in,
  output logic       busy,
  output logic       done,
  output logic       sat
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ARMED      = 3'd1,
    S_WAIT_FIRST = 3'd2,
    S_HIGH       = 3'd3,
    S_LOW        = 3'd4,
    S_SETEND     = 3'd5
  } state_t;

  state_t      r_state, w_next;
  logic [15:0] r_cfg_runlen, r_cfg_timeout, r_cfg_clkfac;
  logic [15:0] r_runlen, r_timeout, r_clkfac;
  logic        r_sig_s1, r_sig_s2, r_syn_s1, r_syn_s2, r_syn_d;
  logic [15:0] r_div, r_delay, r_low, r_setcnt, r_res_delay;
  logic [7:0]  r_high, r_npulses, r_hi_w, r_lo_w, r_res_np, r_res_hi, r_res_lo;
  logic        r_samp;
  logic        w_tick, w_samp, w_rise, w_fall, w_sync_edge, w_last_set;
  logic [15:0] w_tmo, w_low_inc;
  logic [7:0]  w_high_inc, w_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig_s1 <= 1'b0;
      r_sig_s2 <= 1'b0;
      r_syn_s1 <= 1'b0;
      r_syn_s2 <= 1'b0;
      r_syn_d  <= 1'b0;
    end else begin
      r_sig_s1 <= sig_in;
      r_sig_s2 <= r_sig_s1;
      r_syn_s1 <= syncrst;
      r_syn_s2 <= r_syn_s1;
      r_syn_d  <= r_syn_s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_runlen  <= 16'd0;
      r_cfg_timeout <= 16'd0;
      r_cfg_clkfac  <= 16'd0;
    end else if (write) begin
      case (addr)
        4'd10:   r_cfg_runlen[15:8]  <= din;
        4'd11:   r_cfg_runlen[7:0]   <= din;
        4'd12:   r_cfg_timeout[15:8] <= din;
        4'd13:   r_cfg_timeout[7:0]  <= din;
        4'd14:   r_cfg_clkfac[15:8]  <= din;
        4'd15:   r_cfg_clkfac[7:0]   <= din;
        default: ;
      endcase
    end
  end

  assign w_sync_edge = r_syn_s2 & ~r_syn_d;
  assign w_tick      = (r_div == 16'd0) && !suspend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_div <= 16'd0;
    else if (clear)
      r_div <= r_cfg_clkfac;
    else if (!suspend) begin
      if (r_state == S_ARMED && synced && w_sync_edge)
        r_div <= r_clkfac;
      else if (r_div == 16'd0)
        r_div <= r_clkfac;
      else
        r_div <= r_div - 16'd1;
    end
  end

`ifdef PATMON_GLITCH_FILTER_EN
  // A new level is accepted only once two consecutive raw tick samples agree.
  logic r_raw;
  assign w_samp = (r_sig_s2 == r_raw) ? r_sig_s2 : r_samp;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_raw  <= 1'b0;
      r_samp <= 1'b0;
    end else if (w_tick) begin
      r_raw  <= r_sig_s2;
      r_samp <= w_samp;
    end
  end
`else
  assign w_samp = r_sig_s2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_samp <= 1'b0;
    else if (w_tick)
      r_samp <= w_samp;
  end
`endif

  assign w_rise     = w_tick & w_samp & ~r_samp;
  assign w_fall     = w_tick & ~w_samp & r_samp;
  assign w_tmo      = (r_timeout == 16'd0) ? 16'd1 : r_timeout;
  assign w_last_set = (r_runlen != 16'd0) && ((r_setcnt + 16'd1) == r_runlen);
  assign w_high_inc = (r_high == 8'hFF) ? 8'hFF : r_high + 8'd1;
  assign w_low_inc  = r_low + 16'd1;

  always_comb begin
    w_next = r_state;
    if (clear)
      w_next = S_ARMED;
    else if (!suspend) begin
      case (r_state)
        S_IDLE:       w_next = S_IDLE;
        S_ARMED:      if (!synced || w_sync_edge) w_next = S_WAIT_FIRST;
        S_WAIT_FIRST: if (w_rise) w_next = S_HIGH;
        S_HIGH:       if (w_fall) w_next = S_LOW;
        S_LOW: begin
          if (r_low == w_tmo)
            w_next = S_SETEND;
          else if (w_rise)
            w_next = S_HIGH;
        end
        S_SETEND:     w_next = w_last_set ? S_IDLE : S_ARMED;
        default:      w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      busy    <= 1'b0;
    end else begin
      r_state <= w_next;
      busy    <= (w_next == S_WAIT_FIRST) || (w_next == S_HIGH) || (w_next == S_LOW);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_runlen <= 16'd0;  r_timeout <= 16'd0;  r_clkfac <= 16'd0;
      r_delay  <= 16'd0;  r_low     <= 16'd0;  r_setcnt <= 16'd0;
      r_high   <= 8'd0;   r_npulses <= 8'd0;   r_hi_w   <= 8'd0;   r_lo_w <= 8'd0;
      r_res_np <= 8'd0;   r_res_hi  <= 8'd0;   r_res_lo <= 8'd0;   r_res_delay <= 16'd0;
      done     <= 1'b0;   sat       <= 1'b0;
    end else if (clear) begin
      r_runlen <= r_cfg_runlen;  r_timeout <= r_cfg_timeout;  r_clkfac <= r_cfg_clkfac;
      r_delay  <= 16'd0;  r_low     <= 16'd0;  r_setcnt <= 16'd0;
      r_high   <= 8'd0;   r_npulses <= 8'd0;   r_hi_w   <= 8'd0;   r_lo_w <= 8'd0;
      r_res_np <= 8'd0;   r_res_hi  <= 8'd0;   r_res_lo <= 8'd0;   r_res_delay <= 16'd0;
      done     <= 1'b0;   sat       <= 1'b0;
    end else if (!suspend) begin
      case (r_state)
        S_WAIT_FIRST: if (w_tick) begin
          if (w_rise) begin
            r_npulses <= 8'd1;
            r_high    <= 8'd0;
          end else if (r_delay == 16'hFFFF)
            sat <= 1'b1;
          else
            r_delay <= r_delay + 16'd1;
        end
        S_HIGH: if (w_tick) begin
          if (r_high == 8'hFF) sat <= 1'b1;
          // Widths include the edge tick itself, so an N-tick pulse reads N.
          if (w_fall) begin
            r_hi_w <= w_high_inc;
            r_low  <= 16'd0;
          end else
            r_high <= w_high_inc;
        end
        S_LOW: if (r_low != w_tmo && w_tick) begin
          if (w_rise) begin
            if (r_low >= 16'd255) begin
              r_lo_w <= 8'hFF;
              sat    <= 1'b1;
            end else
              r_lo_w <= w_low_inc[7:0];
            if (r_npulses == 8'hFF) sat <= 1'b1;
            else r_npulses <= r_npulses + 8'd1;
            r_high <= 8'd0;
          end else
            r_low <= w_low_inc;
        end
        S_SETEND: begin
          r_res_np    <= r_npulses;
          r_res_hi    <= r_hi_w;
          r_res_lo    <= r_lo_w;
          r_res_delay <= r_delay;
          if (r_setcnt == 16'hFFFF) sat <= 1'b1;
          else r_setcnt <= r_setcnt + 16'd1;
          if (w_last_set)
            done <= 1'b1;
          else begin
            r_delay   <= 16'd0;
            r_npulses <= 8'd0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_rdata = 8'd0;
    case (addr)
      4'd0:    w_rdata = r_res_np;
      4'd1:    w_rdata = r_res_hi;
      4'd2:    w_rdata = r_res_lo;
      4'd3:    w_rdata = {5'b0, sat, done, busy};
      4'd4:    w_rdata = r_res_delay[15:8];
      4'd5:    w_rdata = r_res_delay[7:0];
      4'd6:    w_rdata = r_setcnt[15:8];
      4'd7:    w_rdata = r_setcnt[7:0];
      4'd10:   w_rdata = r_cfg_runlen[15:8];
      4'd11:   w_rdata = r_cfg_runlen[7:0];
      4'd12:   w_rdata = r_cfg_timeout[15:8];
      4'd13:   w_rdata = r_cfg_timeout[7:0];
      4'd14:   w_rdata = r_cfg_clkfac[15:8];
      4'd15:   w_rdata = r_cfg_clkfac[7:0];
      default: w_rdata = 8'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout <= 8'd0;
    else        dout <= w_rdata;
  end

endmodule
`default_nettype wire

// File: tb/tb_sync_async_patmon.sv
`default_nettype none
// ============================================================================
// tb_sync_async_patmon : directed self-checking bench for sync_async_patmon
// Revision 1.0
// ============================================================================
module tb_sync_async_patmon;

  logic       clk = 1'b0, rst_n = 1'b0, clear = 1'b0, suspend = 1'b0, write = 1'b0;
  logic [3:0] addr = 4'd0;
  logic [7:0] din = 8'd0;
  logic [7:0] dout;
  logic       synced = 1'b0, syncrst = 1'b0, sig_in = 1'b0;
  logic       busy, done, sat;
  int         checks = 0, errors = 0;
  int         v;

  always #5 clk = ~clk;

  sync_async_patmon dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .suspend(suspend), .write(write),
    .addr(addr), .din(din), .dout(dout), .synced(synced), .syncrst(syncrst),
    .sig_in(sig_in), .busy(busy), .done(done), .sat(sat)
  );

  typedef struct {
    int clkfac; int timeout; int pre; int hi; int lo; int n; int tol;
    int exp_np; int exp_hi; int exp_lo; int exp_dly; int exp_status;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk); addr = a; din = d; write = 1'b1;
    @(negedge clk); write = 1'b0;
  endtask

  task automatic set_cfg(input logic [15:0] rl, input logic [15:0] tm, input logic [15:0] cf);
    wr(4'd10, rl[15:8]); wr(4'd11, rl[7:0]);
    wr(4'd12, tm[15:8]); wr(4'd13, tm[7:0]);
    wr(4'd14, cf[15:8]); wr(4'd15, cf[7:0]);
  endtask

  task automatic rd(input logic [3:0] a, output int r);
    @(negedge clk); addr = a;
    @(negedge clk); r = int'(dout);
  endtask

  task automatic rd16(input logic [3:0] a, output int r);
    int h, l;
    rd(a, h);
    rd(a + 4'd1, l);
    r = h * 256 + l;
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1; sig_in = 1'b0;
    @(negedge clk); clear = 1'b0;
  endtask

  task automatic pulse(input int hi, input int lo);
    sig_in = 1'b1; repeat (hi) @(negedge clk);
    sig_in = 1'b0; repeat (lo) @(negedge clk);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 4000; i++) begin
      if (done) break;
      @(negedge clk);
    end
    chk(name, int'(done), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //        clkfac tmo pre  hi  lo  n tol  np  hi  lo dly status
    vecs[0] = '{0,    20, 12,   5,  7, 3, 1,   3,  5,  7, 12, 2};
    vecs[1] = '{3,    10, 20,  40,  8, 1, 1,   1, 10,  0,  5, 2};
    vecs[2] = '{1,     8, 10,   6,  4, 4, 1,   4,  3,  2,  5, 2};
    vecs[3] = '{0,     0,  4,   3, 10, 2, 1,   1,  3,  0,  4, 2};
    vecs[4] = '{0,     5,  3, 300, 10, 1, 0,   1, 255, 0,  3, 6};

    repeat (3) @(negedge clk);
    chk("reset_dout", int'(dout), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_sat", int'(sat), 0);
    rst_n = 1'b1;
    rd(4'd3, v); chk("reset_status", v, 0);
    rd16(4'd6, v); chk("reset_setcnt", v, 0);

    set_cfg(16'h1234, 16'h5678, 16'h9ABC);
    rd(4'd10, v); chk("cfg_rb_runlen_hi", v, 'h12);
    rd(4'd13, v); chk("cfg_rb_timeout_lo", v, 'h78);
    rd(4'd15, v); chk("cfg_rb_clkfac_lo", v, 'hBC);
    rd(4'd8, v);  chk("cfg_rb_addr8", v, 0);

    for (int k = 0; k < 5; k++) begin
      synced = 1'b0;
      set_cfg(16'd1, 16'(vecs[k].timeout), 16'(vecs[k].clkfac));
      do_clear();
      repeat (vecs[k].pre - 1) @(negedge clk);
      for (int p = 0; p < vecs[k].n; p++) pulse(vecs[k].hi, vecs[k].lo);
      wait_done($sformatf("v%0d_done", k));
      rd(4'd0, v);   chk($sformatf("v%0d_npulses", k), v, vecs[k].exp_np);
      rd(4'd1, v);   chk_rng($sformatf("v%0d_high", k), v, vecs[k].exp_hi - vecs[k].tol, vecs[k].exp_hi + vecs[k].tol);
      rd(4'd2, v);   chk_rng($sformatf("v%0d_low", k), v, vecs[k].exp_lo - vecs[k].tol, vecs[k].exp_lo + vecs[k].tol);
      rd16(4'd4, v); chk_rng($sformatf("v%0d_delay", k), v, vecs[k].exp_dly - vecs[k].tol, vecs[k].exp_dly + vecs[k].tol);
      rd(4'd3, v);   chk($sformatf("v%0d_status", k), v, vecs[k].exp_status);
      rd16(4'd6, v); chk($sformatf("v%0d_setcnt", k), v, 1);
    end

    // Asynchronous reset in the middle of a cycle, with done and sat both set.
    rd(4'd3, v); chk("pre_rst_status", v, 6);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    chk("arst_dout", int'(dout), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_sat", int'(sat), 0);
    @(negedge clk); rst_n = 1'b1;

    // Synced sets: pulse 30 clk after each syncrst, extra syncrst during HIGH.
    set_cfg(16'd3, 16'd10, 16'd0);
    synced = 1'b1;
    do_clear();
    for (int k = 1; k <= 3; k++) begin
      repeat (5) @(negedge clk);
      syncrst = 1'b1; @(negedge clk); syncrst = 1'b0;
      repeat (29) @(negedge clk);
      sig_in = 1'b1; repeat (5) @(negedge clk);
      syncrst = 1'b1; @(negedge clk); syncrst = 1'b0;
      repeat (4) @(negedge clk);
      sig_in = 1'b0; repeat (25) @(negedge clk);
      rd16(4'd4, v); chk_rng($sformatf("sync%0d_delay", k), v, 29, 31);
      rd(4'd0, v);   chk($sformatf("sync%0d_npulses", k), v, 1);
      rd(4'd1, v);   chk_rng($sformatf("sync%0d_high", k), v, 9, 11);
      rd16(4'd6, v); chk($sformatf("sync%0d_setcnt", k), v, k);
      chk($sformatf("sync%0d_done", k), int'(done), (k == 3) ? 1 : 0);
    end

    // Clear mid-HIGH in synced mode: set aborts and stays armed.
    set_cfg(16'd1, 16'd10, 16'd0);
    do_clear();
    repeat (3) @(negedge clk);
    syncrst = 1'b1; @(negedge clk); syncrst = 1'b0;
    repeat (10) @(negedge clk);
    sig_in = 1'b1; repeat (8) @(negedge clk);
    chk("midhigh_busy_before", int'(busy), 1);
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    chk("clr_busy", int'(busy), 0);
    chk("clr_done", int'(done), 0);
    rd(4'd0, v);   chk("clr_npulses", v, 0);
    rd16(4'd6, v); chk("clr_setcnt", v, 0);
    sig_in = 1'b0; repeat (30) @(negedge clk);
    chk("clr_busy_later", int'(busy), 0);
    rd(4'd3, v);   chk("clr_status", v, 0);

    // Suspend for 50 clk during a low gap.
    synced = 1'b0;
    set_cfg(16'd1, 16'd40, 16'd0);
    do_clear();
    repeat (4) @(negedge clk);
    sig_in = 1'b1; repeat (5) @(negedge clk);
    sig_in = 1'b0; repeat (10) @(negedge clk);
    suspend = 1'b1; repeat (50) @(negedge clk); suspend = 1'b0;
    repeat (5) @(negedge clk);
    pulse(5, 5);
    wait_done("susp_done");
    rd(4'd0, v); chk("susp_npulses", v, 2);
    rd(4'd2, v); chk_rng("susp_low", v, 14, 16);
    rd(4'd1, v); chk_rng("susp_high", v, 4, 6);

    // Single-clk glitch at clkfac=0.
    set_cfg(16'd1, 16'd5, 16'd0);
    do_clear();
    repeat (5) @(negedge clk);
    sig_in = 1'b1; @(negedge clk); sig_in = 1'b0;
`ifdef PATMON_GLITCH_FILTER_EN
    repeat (20) @(negedge clk);
    chk("glitch_done", int'(done), 0);
    chk("glitch_busy", int'(busy), 1);
    pulse(3, 3);
    wait_done("glitch_after_done");
    rd(4'd0, v); chk("glitch_npulses", v, 1);
`else
    wait_done("glitch_done");
    rd(4'd0, v); chk("glitch_npulses", v, 1);
    rd(4'd1, v); chk("glitch_high", v, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
